// File: rtl/led7seg_scan_driver_if.sv
// Bundle between display-value logic and the 7-segment scan driver:
// shadow-load buses in, multiplexed segment/select pins out.
interface led7seg_scan_driver_if #(
  parameter int DIGITS = 4
);
  logic                  load;
  logic [4*DIGITS-1:0]   digits_in;
  logic [DIGITS-1:0]     valid_in;
  logic [DIGITS-1:0]     dp_in;
  logic [DIGITS-1:0]     blink_in;
  logic [7:0]            seg;
  logic [DIGITS-1:0]     sel;

  modport master (
    output load, digits_in, valid_in, dp_in, blink_in,
    input  seg, sel
  );

  modport slave (
    input  load, digits_in, valid_in, dp_in, blink_in,
    output seg, sel
  );
endinterface

// File: rtl/led7seg_scan_driver.sv
// Time-multiplexed 7-segment driver: shadow registers, hex decode, decimal
// points, per-digit blanking/blinking and a one-cycle ghost guard per slot.
module led7seg_scan_driver #(
  parameter int DIGITS       = 4,
  parameter int SCAN_DIV     = 50000,
  parameter int BLINK_FRAMES = 100,
  parameter bit HEX_EN       = 1'b1,
  parameter bit SEG_INV      = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  led7seg_scan_driver_if.slave  bus
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [7:0] SEG_OFF = SEG_INV ? 8'hFF : 8'h00;

  logic [4*DIGITS-1:0] digits_reg;
  logic [DIGITS-1:0]   valid_reg;
  logic [DIGITS-1:0]   dp_reg;
  logic [DIGITS-1:0]   blink_reg;
  logic [CW-1:0]       cnt_reg;
  logic [IW-1:0]       idx_reg;
  logic [FW-1:0]       frame_reg;
  logic                blink_ph_reg;
  logic [7:0]          seg_reg;
  logic [DIGITS-1:0]   sel_reg;

  logic                slot_end;
  logic                frame_end;
  logic                blink_end;
  logic [7:0]          seg_next;
  logic [DIGITS-1:0]   sel_next;
  logic [7:0]          digit_seg [DIGITS];

  function automatic logic [6:0] decode(input logic [3:0] v);
    logic [6:0] r;
    r = 7'h00;
    case (v)
      4'h0: r = 7'h3F;
      4'h1: r = 7'h06;
      4'h2: r = 7'h5B;
      4'h3: r = 7'h4F;
      4'h4: r = 7'h66;
      4'h5: r = 7'h6D;
      4'h6: r = 7'h7D;
      4'h7: r = 7'h07;
      4'h8: r = 7'h7F;
      4'h9: r = 7'h6F;
      4'hA: r = HEX_EN ? 7'h77 : 7'h00;
      4'hB: r = HEX_EN ? 7'h7C : 7'h00;
      4'hC: r = HEX_EN ? 7'h39 : 7'h00;
      4'hD: r = HEX_EN ? 7'h5E : 7'h00;
      4'hE: r = HEX_EN ? 7'h79 : 7'h00;
      4'hF: r = HEX_EN ? 7'h71 : 7'h00;
      default: r = 7'h00;
    endcase
    return r;
  endfunction

  // Pre-decode every digit so the scan mux only selects a finished pattern.
  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_dec
    assign digit_seg[gi] = (valid_reg[gi] && !(blink_reg[gi] && blink_ph_reg))
                           ? {dp_reg[gi], decode(digits_reg[4*gi +: 4])}
                           : 8'h00;
  end

  assign slot_end  = (cnt_reg == CW'(SCAN_DIV - 1));
  assign frame_end = slot_end && (idx_reg == IW'(DIGITS - 1));
  assign blink_end = frame_end && (frame_reg == FW'(BLINK_FRAMES - 1));

  // Last count of each slot drives everything off so the next digit never ghosts.
  always_comb begin
    sel_next = '0;
    seg_next = 8'h00;
    if (!slot_end) begin
      sel_next = {{(DIGITS-1){1'b0}}, 1'b1} << idx_reg;
      seg_next = digit_seg[idx_reg];
    end
    seg_next = seg_next ^ {8{SEG_INV}};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      digits_reg   <= '0;
      valid_reg    <= '0;
      dp_reg       <= '0;
      blink_reg    <= '0;
      cnt_reg      <= '0;
      idx_reg      <= '0;
      frame_reg    <= '0;
      blink_ph_reg <= 1'b0;
      sel_reg      <= '0;
      seg_reg      <= SEG_OFF;
    end else begin
      if (bus.load) begin
        digits_reg <= bus.digits_in;
        valid_reg  <= bus.valid_in;
        dp_reg     <= bus.dp_in;
        blink_reg  <= bus.blink_in;
      end
      cnt_reg <= slot_end ? '0 : cnt_reg + CW'(1);
      if (slot_end) begin
        idx_reg <= frame_end ? '0 : idx_reg + IW'(1);
      end
      if (frame_end) begin
        frame_reg <= blink_end ? '0 : frame_reg + FW'(1);
      end
      if (blink_end) begin
        blink_ph_reg <= ~blink_ph_reg;
      end
      sel_reg <= sel_next;
      seg_reg <= seg_next;
    end
  end

  assign bus.seg = seg_reg;
  assign bus.sel = sel_reg;

endmodule

// File: tb/tb_led7seg_scan_driver.sv
// Directed bench for led7seg_scan_driver: default build, HEX_EN=0 build and
// SEG_INV=1 build run side by side on identical stimulus.
module tb_led7seg_scan_driver;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  logic [3:0] seq_exp [8];
  logic [7:0] exp0 [4];
  logic [7:0] exp1 [4];

  led7seg_scan_driver_if #(.DIGITS(4)) if0 ();
  led7seg_scan_driver_if #(.DIGITS(4)) if1 ();
  led7seg_scan_driver_if #(.DIGITS(4)) if2 ();

  led7seg_scan_driver #(.DIGITS(4), .SCAN_DIV(4), .BLINK_FRAMES(2), .HEX_EN(1'b1), .SEG_INV(1'b0))
    dut0 (.clk(clk), .rst(rst), .bus(if0));
  led7seg_scan_driver #(.DIGITS(4), .SCAN_DIV(4), .BLINK_FRAMES(2), .HEX_EN(1'b0), .SEG_INV(1'b0))
    dut1 (.clk(clk), .rst(rst), .bus(if1));
  led7seg_scan_driver #(.DIGITS(4), .SCAN_DIV(4), .BLINK_FRAMES(2), .HEX_EN(1'b1), .SEG_INV(1'b1))
    dut2 (.clk(clk), .rst(rst), .bus(if2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic ld, input logic [15:0] dig, input logic [3:0] val,
                        input logic [3:0] dp, input logic [3:0] blk);
    if0.load = ld; if0.digits_in = dig; if0.valid_in = val; if0.dp_in = dp; if0.blink_in = blk;
    if1.load = ld; if1.digits_in = dig; if1.valid_in = val; if1.dp_in = dp; if1.blink_in = blk;
    if2.load = ld; if2.digits_in = dig; if2.valid_in = val; if2.dp_in = dp; if2.blink_in = blk;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Advance until the select bus shows the wanted pattern; give up after a bounded budget.
  task automatic wait_sel(input logic [3:0] want);
    int n;
    n = 0;
    while (if0.sel !== want && n < 64) begin
      tick();
      n++;
    end
    checks++;
    assert (if0.sel === want) else begin
      errors++;
      $error("FAIL wait_sel observed %b expected %b", if0.sel, want);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    seq_exp = '{4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0010, 4'b0010, 4'b0010, 4'b0000};

    // 1. reset state and raw scan sequence
    rst = 1'b1;
    set_in(1'b0, 16'h0000, 4'h0, 4'h0, 4'h0);
    repeat (10) tick();
    check("rst_sel", {4'b0, if0.sel}, 8'h00);
    check("rst_seg", if0.seg, 8'h00);
    check("rst_seg_inv", if2.seg, 8'hFF);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      check($sformatf("scan_sel[%0d]", i), {4'b0, if0.sel}, {4'b0, seq_exp[i]});
      check($sformatf("scan_seg[%0d]", i), if0.seg, 8'h00);
    end

    // 2. decimal digits 1234
    set_in(1'b1, 16'h1234, 4'hF, 4'h0, 4'h0);
    tick();
    set_in(1'b0, 16'h1234, 4'hF, 4'h0, 4'h0);
    tick(); tick();
    exp0 = '{8'h66, 8'h4F, 8'h5B, 8'h06};
    for (int d = 0; d < 4; d++) begin
      wait_sel(4'b0001 << d);
      check($sformatf("dec_seg[%0d]", d), if0.seg, exp0[d]);
      check($sformatf("dec_seg_nohex[%0d]", d), if1.seg, exp0[d]);
    end
    wait_sel(4'b0000);
    check("dead_seg", if0.seg, 8'h00);
    check("dead_seg_inv", if2.seg, 8'hFF);

    // 3. hex digits with a decimal point on digit 0
    set_in(1'b1, 16'hFA90, 4'hF, 4'b0001, 4'h0);
    tick();
    set_in(1'b0, 16'hFA90, 4'hF, 4'b0001, 4'h0);
    tick(); tick();
    exp0 = '{8'hBF, 8'h6F, 8'h77, 8'h71};
    exp1 = '{8'hBF, 8'h6F, 8'h00, 8'h00};
    for (int d = 0; d < 4; d++) begin
      wait_sel(4'b0001 << d);
      check($sformatf("hex_seg[%0d]", d), if0.seg, exp0[d]);
      check($sformatf("hex_off_seg[%0d]", d), if1.seg, exp1[d]);
    end

    // 4. digit 2 invalid, its dp must stay dark too
    set_in(1'b1, 16'h1834, 4'b1011, 4'b0100, 4'h0);
    tick();
    set_in(1'b0, 16'h1834, 4'b1011, 4'b0100, 4'h0);
    tick(); tick();
    exp0 = '{8'h66, 8'h4F, 8'h00, 8'h06};
    for (int d = 0; d < 4; d++) begin
      wait_sel(4'b0001 << d);
      check($sformatf("valid_seg[%0d]", d), if0.seg, exp0[d]);
    end

    // 5. blink digit 2 from a fresh frame 0
    rst = 1'b1;
    tick();
    rst = 1'b0;
    set_in(1'b1, 16'h0800, 4'hF, 4'h0, 4'b0100);
    tick();
    set_in(1'b0, 16'h0800, 4'hF, 4'h0, 4'b0100);
    for (int f = 0; f < 6; f++) begin
      wait_sel(4'b0100);
      check($sformatf("blink_seg[f%0d]", f), if0.seg, ((f / 2) % 2 == 1) ? 8'h00 : 8'h7F);
      check($sformatf("blink_seg_inv[f%0d]", f), if2.seg, ((f / 2) % 2 == 1) ? 8'hFF : 8'h80);
      wait_sel(4'b1000);
    end

    // 6. mid-slot load, then reset mid-frame with a competing load
    set_in(1'b1, 16'h1111, 4'hF, 4'h0, 4'h0);
    tick();
    set_in(1'b0, 16'h1111, 4'hF, 4'h0, 4'h0);
    wait_sel(4'b0010);
    set_in(1'b1, 16'h0000, 4'hF, 4'h0, 4'h0);
    tick();
    set_in(1'b0, 16'h0000, 4'hF, 4'h0, 4'h0);
    check("midload_sel_a", {4'b0, if0.sel}, 8'h02);
    tick();
    check("midload_sel_b", {4'b0, if0.sel}, 8'h02);
    check("midload_seg", if0.seg, 8'h3F);
    check("midload_seg_inv", if2.seg, 8'hC0);
    wait_sel(4'b0100);
    tick();
    rst = 1'b1;
    set_in(1'b1, 16'h8888, 4'hF, 4'hF, 4'h0);
    tick();
    check("midrst_sel", {4'b0, if0.sel}, 8'h00);
    check("midrst_seg", if0.seg, 8'h00);
    check("midrst_seg_inv", if2.seg, 8'hFF);
    rst = 1'b0;
    set_in(1'b0, 16'h8888, 4'hF, 4'hF, 4'h0);
    tick();
    check("restart_sel", {4'b0, if0.sel}, 8'h01);
    check("restart_seg", if0.seg, 8'h00);
    check("restart_seg_inv", if2.seg, 8'hFF);
    wait_sel(4'b0100);
    check("cleared_seg", if0.seg, 8'h00);
    check("cleared_seg_inv", if2.seg, 8'hFF);
    wait_sel(4'b0000);
    check("cleared_dead_inv", if2.seg, 8'hFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
